ram_dma: RTL

RAM_DMA -- requirements
Module: ram_dma

---
 rtl/ram_dma.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ram_dma.sv
// Word-copy / word-fill DMA engine for a single-port RAM with an active-low write strobe.
// A copy takes a READ and a WRITE cycle per word; a fill takes one WRITE cycle per word.
module ram_dma (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        mode,
   input  logic [15:0] src,
   input  logic [15:0] dst,
   input  logic [15:0] len,
   input  logic [15:0] fill_val,
   input  logic [15:0] rd_data,
   output logic [15:0] address,
   output logic [15:0] wr_data,
   output logic        load_bar,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic        mode_r;
   logic [15:0] src_ptr_r;
   logic [15:0] dst_ptr_r;
   logic [15:0] remaining_r;
   logic [15:0] data_r;
   logic [15:0] fill_r;

   // State register and transfer context; pointers wrap naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         mode_r      <= 1'b0;
         src_ptr_r   <= 16'h0000;
         dst_ptr_r   <= 16'h0000;
         remaining_r <= 16'h0000;
         data_r      <= 16'h0000;
         fill_r      <= 16'h0000;
      end else begin
         state_r <= state_s;
         case (state_r)
            IDLE: begin
               if (start) begin
                  mode_r      <= mode;
                  src_ptr_r   <= src;
                  dst_ptr_r   <= dst;
                  remaining_r <= len;
                  fill_r      <= fill_val;
               end
            end
            READ: begin
               data_r <= rd_data;
            end
            WRITE: begin
               src_ptr_r   <= src_ptr_r + 16'd1;
               dst_ptr_r   <= dst_ptr_r + 16'd1;
               remaining_r <= remaining_r - 16'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (len == 16'd0) begin
                  state_s = DONE;
               end else if (mode) begin
                  state_s = WRITE;
               end else begin
                  state_s = READ;
               end
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            state_s = WRITE;
         end
         WRITE: begin
            if (remaining_r == 16'd1) begin
               state_s = DONE;
            end else if (mode_r) begin
               state_s = WRITE;
            end else begin
               state_s = READ;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // RAM-side outputs; the strobe is held off whenever reset is high so a reset edge never writes.
   always_comb begin
      address  = 16'h0000;
      wr_data  = 16'h0000;
      load_bar = 1'b1;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_r)
         IDLE: begin
         end
         READ: begin
            address = src_ptr_r;
            busy    = 1'b1;
         end
         WRITE: begin
            address  = dst_ptr_r;
            load_bar = reset;
            busy     = 1'b1;
            if (mode_r) begin
               wr_data = fill_r;
            end else begin
               wr_data = data_r;
            end
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
